receive_data: RTL and testbench

RECEIVE_DATA -- requirements
Module: receive_data

---
 rtl/receive_data.sv | 222 ++++++++++++++++++++++
 tb/tb_receive_data.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/receive_data.sv
// UART 8N1 receiver with ASCII-hex byte assembly and a
// FE/len/cmd/payload/EF frame parser driving lock flags.
module receive_data #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic RX,
  output logic LOCKEDST,
  output logic LOCKEDL,
  output logic LOCKEDCMD_N_DATA,
  output logic LOCKEDCMD_PREPARE_RET,
  output logic LOCKEDN
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_WIDTH);
  localparam int DW = DATA_WIDTH;

  typedef enum logic [1:0] {
    U_IDLE, U_START, U_DATA, U_STOP
  } ustate_t;

  typedef enum logic [1:0] {
    P_IDLE, P_LEN, P_CMD, P_PAYLOAD
  } pstate_t;

  logic          r_rx_s1, r_rx_s2, r_rx_d;
  ustate_t       r_us;
  logic [CW-1:0] r_clk_cnt;
  logic [BW-1:0] r_bit;
  logic [DW-1:0] r_shift;
  logic [DW-1:0] r_char;
  logic          r_char_valid;

  logic          r_have_hi;
  logic [3:0]    r_hi;
  logic [7:0]    r_byte;
  logic          r_byte_valid;
  logic          r_bad;

  pstate_t       r_ps;
  logic [7:0]    r_len;
  logic [7:0]    r_cnt;
  logic [7:0]    r_cmd;
  logic [7:0]    r_n;

  logic          w_is_hex;
  logic [3:0]    w_nib;
  logic [7:0]    w_cnt_nx;
  logic          w_close;

  // r_rx_d is the previous synchronized sample, used for edge detect
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_s1      <= 1'b1;
      r_rx_s2      <= 1'b1;
      r_rx_d       <= 1'b1;
      r_us         <= U_IDLE;
      r_clk_cnt    <= '0;
      r_bit        <= '0;
      r_shift      <= '0;
      r_char       <= '0;
      r_char_valid <= 1'b0;
    end else begin
      r_rx_s1      <= RX;
      r_rx_s2      <= r_rx_s1;
      r_rx_d       <= r_rx_s2;
      r_char_valid <= 1'b0;
      unique case (r_us)
        U_IDLE: begin
          if (r_rx_d && !r_rx_s2) begin
            r_us      <= U_START;
            r_clk_cnt <= '0;
          end
        end
        U_START: begin
          if (r_clk_cnt == CW'(CLKS_PER_BIT/2 - 1)) begin
            r_clk_cnt <= '0;
            r_bit     <= '0;
            r_us      <= r_rx_s2 ? U_IDLE : U_DATA;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        U_DATA: begin
          if (r_clk_cnt == CW'(CLKS_PER_BIT - 1)) begin
            r_clk_cnt <= '0;
            r_shift   <= {r_rx_s2, r_shift[DW-1:1]};
            if (r_bit == BW'(DW - 1)) r_us <= U_STOP;
            else r_bit <= r_bit + 1'b1;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        U_STOP: begin
          if (r_clk_cnt == CW'(CLKS_PER_BIT - 1)) begin
            r_clk_cnt <= '0;
            r_us      <= U_IDLE;
            if (r_rx_s2) begin
              r_char       <= r_shift;
              r_char_valid <= 1'b1;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        default: r_us <= U_IDLE;
      endcase
    end
  end

  always_comb begin
    w_is_hex = 1'b0;
    w_nib    = 4'h0;
    if (r_char >= DW'(8'h30) && r_char <= DW'(8'h39)) begin
      w_is_hex = 1'b1;
      w_nib    = 4'(r_char - DW'(8'h30));
    end else if (r_char >= DW'(8'h41) &&
                 r_char <= DW'(8'h46)) begin
      w_is_hex = 1'b1;
      w_nib    = 4'(r_char - DW'(8'h37));
    end else if (r_char >= DW'(8'h61) &&
                 r_char <= DW'(8'h66)) begin
      w_is_hex = 1'b1;
      w_nib    = 4'(r_char - DW'(8'h57));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_have_hi    <= 1'b0;
      r_hi         <= 4'h0;
      r_byte       <= 8'h00;
      r_byte_valid <= 1'b0;
      r_bad        <= 1'b0;
    end else begin
      r_byte_valid <= 1'b0;
      r_bad        <= 1'b0;
      if (r_char_valid) begin
        if (!w_is_hex) begin
          r_have_hi <= 1'b0;
          r_bad     <= 1'b1;
        end else if (r_have_hi) begin
          r_byte       <= {r_hi, w_nib};
          r_byte_valid <= 1'b1;
          r_have_hi    <= 1'b0;
        end else begin
          r_hi      <= w_nib;
          r_have_hi <= 1'b1;
        end
      end
    end
  end

  // Counter includes the cmd byte, so the terminator sits at count L
  assign w_cnt_nx = r_cnt + 8'd1;

  always_comb begin
    w_close = r_bad;
    if (r_byte_valid) begin
      if (r_ps == P_LEN && r_byte < 8'd2) w_close = 1'b1;
      if (r_ps == P_PAYLOAD && w_cnt_nx == r_len)
        w_close = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ps                  <= P_IDLE;
      r_len                 <= 8'h00;
      r_cnt                 <= 8'h00;
      r_cmd                 <= 8'h00;
      r_n                   <= 8'h00;
      LOCKEDST              <= 1'b0;
      LOCKEDL               <= 1'b0;
      LOCKEDCMD_N_DATA      <= 1'b0;
      LOCKEDCMD_PREPARE_RET <= 1'b0;
      LOCKEDN               <= 1'b0;
    end else if (w_close) begin
      r_ps                  <= P_IDLE;
      LOCKEDST              <= 1'b0;
      LOCKEDL               <= 1'b0;
      LOCKEDCMD_N_DATA      <= 1'b0;
      LOCKEDCMD_PREPARE_RET <= 1'b0;
    end else if (r_byte_valid) begin
      unique case (r_ps)
        P_IDLE: begin
          if (r_byte == 8'hFE) begin
            LOCKEDST <= 1'b1;
            r_ps     <= P_LEN;
          end
        end
        P_LEN: begin
          r_len   <= r_byte;
          r_cnt   <= 8'h00;
          LOCKEDL <= 1'b1;
          r_ps    <= P_CMD;
        end
        P_CMD: begin
          r_cnt <= 8'd1;
          r_cmd <= r_byte;
          LOCKEDCMD_N_DATA <=
            (r_byte == 8'h01) || (r_byte == 8'h04);
          LOCKEDCMD_PREPARE_RET <=
            (r_byte == 8'h02) || (r_byte == 8'h03);
          r_ps <= P_PAYLOAD;
        end
        P_PAYLOAD: begin
          r_cnt <= w_cnt_nx;
          if (r_cmd == 8'h01 && w_cnt_nx == 8'd2) begin
            r_n     <= r_byte;
            LOCKEDN <= 1'b1;
          end
        end
        default: r_ps <= P_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_receive_data.sv
// Directed bench for receive_data: hex-encoded UART frames
// checked against hand-computed flag vectors.
module tb_receive_data;

  localparam int CPB = 20;

  logic clk = 1'b0;
  logic reset;
  logic RX;
  logic LOCKEDST, LOCKEDL, LOCKEDCMD_N_DATA;
  logic LOCKEDCMD_PREPARE_RET, LOCKEDN;
  logic [4:0] flags;

  int n_pass = 0;
  int n_tot  = 0;

  receive_data #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB)) dut (
    .clk                  (clk),
    .reset                (reset),
    .RX                   (RX),
    .LOCKEDST             (LOCKEDST),
    .LOCKEDL              (LOCKEDL),
    .LOCKEDCMD_N_DATA     (LOCKEDCMD_N_DATA),
    .LOCKEDCMD_PREPARE_RET(LOCKEDCMD_PREPARE_RET),
    .LOCKEDN              (LOCKEDN)
  );

  always #5 clk = ~clk;

  // {ST, L, N_DATA, PREPARE_RET, N}
  assign flags = {LOCKEDST, LOCKEDL, LOCKEDCMD_N_DATA,
                  LOCKEDCMD_PREPARE_RET, LOCKEDN};

  task automatic bit_out(input logic b);
    RX = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_char(input logic [7:0] c,
                           input logic stop);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(c[i]);
    bit_out(stop);
    bit_out(1'b1);
    bit_out(1'b1);
  endtask

  function automatic logic [7:0] hexc(input logic [3:0] n,
                                      input logic lc);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    return (lc ? 8'h57 : 8'h37) + {4'h0, n};
  endfunction

  task automatic send_byte(input logic [7:0] b,
                           input logic lc = 1'b0);
    send_char(hexc(b[7:4], lc), 1'b1);
    send_char(hexc(b[3:0], lc), 1'b1);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    RX    = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (100) @(negedge clk);
    n_tot++;
    if (flags !== 5'b00000)
      $display("FAIL reset_flags got %b want 00000", flags);
    else n_pass++;
    n_tot++;
    if (dut.r_n !== 8'h00)
      $display("FAIL reset_n got %h want 00", dut.r_n);
    else n_pass++;
  endtask

  task automatic test_set_n;
    send_byte(8'hFE);
    n_tot++;
    if (flags !== 5'b10000)
      $display("FAIL setn_fe got %b want 10000", flags);
    else n_pass++;
    send_byte(8'h03);
    n_tot++;
    if (flags !== 5'b11000)
      $display("FAIL setn_len got %b want 11000", flags);
    else n_pass++;
    send_byte(8'h01);
    n_tot++;
    if (flags !== 5'b11100)
      $display("FAIL setn_cmd got %b want 11100", flags);
    else n_pass++;
    send_byte(8'h05);
    n_tot++;
    if (flags !== 5'b11101)
      $display("FAIL setn_pay got %b want 11101", flags);
    else n_pass++;
    send_byte(8'hEF);
    n_tot++;
    if (flags !== 5'b00001)
      $display("FAIL setn_ef got %b want 00001", flags);
    else n_pass++;
    n_tot++;
    if (dut.r_n !== 8'h05)
      $display("FAIL setn_n got %h want 05", dut.r_n);
    else n_pass++;
  endtask

  task automatic test_prepare;
    send_byte(8'hFE);
    send_byte(8'h02);
    send_byte(8'h03);
    n_tot++;
    if (flags !== 5'b11011)
      $display("FAIL prep_cmd got %b want 11011", flags);
    else n_pass++;
    send_byte(8'hEF);
    n_tot++;
    if (flags !== 5'b00001)
      $display("FAIL prep_ef got %b want 00001", flags);
    else n_pass++;
  endtask

  task automatic test_long_payload;
    logic [7:0] b;
    send_byte(8'hFE);
    send_byte(8'h32);
    send_byte(8'h04);
    for (int i = 0; i < 48; i++) begin
      b = 8'(i);
      if (i == 10) b = 8'hEF;
      if (i == 20) b = 8'hFE;
      send_byte(b, 1'b1);
      n_tot++;
      if (flags !== 5'b11101)
        $display("FAIL long_pay%0d got %b want 11101",
                 i, flags);
      else n_pass++;
    end
    send_byte(8'hEF);
    n_tot++;
    if (flags !== 5'b00001)
      $display("FAIL long_ef got %b want 00001", flags);
    else n_pass++;
  endtask

  task automatic test_bad_term;
    send_byte(8'hFE);
    send_byte(8'h03);
    send_byte(8'h01);
    send_byte(8'h07);
    n_tot++;
    if (flags !== 5'b11101)
      $display("FAIL badt_pay got %b want 11101", flags);
    else n_pass++;
    send_byte(8'hAA);
    n_tot++;
    if (flags !== 5'b00001)
      $display("FAIL badt_aa got %b want 00001", flags);
    else n_pass++;
    n_tot++;
    if (dut.r_n !== 8'h07)
      $display("FAIL badt_n got %h want 07", dut.r_n);
    else n_pass++;
    send_byte(8'hFE);
    n_tot++;
    if (flags !== 5'b10001)
      $display("FAIL badt_fe2 got %b want 10001", flags);
    else n_pass++;
    send_byte(8'h02);
    send_byte(8'h03);
    n_tot++;
    if (flags !== 5'b11011)
      $display("FAIL badt_cmd2 got %b want 11011", flags);
    else n_pass++;
    send_byte(8'hEF);
    n_tot++;
    if (flags !== 5'b00001)
      $display("FAIL badt_ef2 got %b want 00001", flags);
    else n_pass++;
  endtask

  task automatic test_errors;
    send_char(8'h46, 1'b1);
    send_char(8'h45, 1'b0);
    n_tot++;
    if (flags !== 5'b00001)
      $display("FAIL stop0 got %b want 00001", flags);
    else n_pass++;
    send_char(8'h45, 1'b1);
    n_tot++;
    if (flags !== 5'b10001)
      $display("FAIL stop0_keep got %b want 10001", flags);
    else n_pass++;
    send_char(8'h47, 1'b1);
    n_tot++;
    if (flags !== 5'b00001)
      $display("FAIL g_abort got %b want 00001", flags);
    else n_pass++;
    send_byte(8'hFE);
    n_tot++;
    if (flags !== 5'b10001)
      $display("FAIL g_idle got %b want 10001", flags);
    else n_pass++;
    send_byte(8'h01);
    n_tot++;
    if (flags !== 5'b00001)
      $display("FAIL short_len got %b want 00001", flags);
    else n_pass++;
  endtask

  task automatic test_mid_reset;
    send_byte(8'hFE);
    send_byte(8'h03);
    n_tot++;
    if (flags !== 5'b11001)
      $display("FAIL mrst_pre got %b want 11001", flags);
    else n_pass++;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_tot++;
    if (flags !== 5'b00000)
      $display("FAIL mrst_flags got %b want 00000", flags);
    else n_pass++;
    n_tot++;
    if (dut.r_n !== 8'h00)
      $display("FAIL mrst_n got %h want 00", dut.r_n);
    else n_pass++;
    send_byte(8'hFE);
    send_byte(8'h02);
    send_byte(8'h02);
    n_tot++;
    if (flags !== 5'b11010)
      $display("FAIL mrst_frame got %b want 11010", flags);
    else n_pass++;
    send_byte(8'hEF);
    n_tot++;
    if (flags !== 5'b00000)
      $display("FAIL mrst_ef got %b want 00000", flags);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_set_n();
    test_prepare();
    test_long_payload();
    test_bad_term();
    test_errors();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
